// File: rtl/clk_rst_pkg.sv
`default_nettype none
// ------------------------------------------------------------------------
// clk_rst_pkg : state encoding and parameter defaults for clk_lock_reset_ctrl. Rev 1.0
// ------------------------------------------------------------------------
package clk_rst_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_PULSE     = 2'd0;
  localparam state_t ST_WAIT_LOCK = 2'd1;
  localparam state_t ST_HOLD      = 2'd2;
  localparam state_t ST_RUN       = 2'd3;

  localparam int DEF_PULSE_CYCLES   = 4;
  localparam int DEF_HOLD_CYCLES    = 16;
  localparam int DEF_TIMEOUT_CYCLES = 1024;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // A single-cycle phase still needs a 1-bit counter to hold the value 0.
  function automatic int cnt_width(input int max_val);
    int w;
    w = $clog2(max_val);
    return (w < 1) ? 1 : w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ------------------------------------------------------------------------
// sync_2ff : 1-bit two-flop synchronizer, async active-high reset to 0. Rev 1.0
// ------------------------------------------------------------------------
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule
`default_nettype wire

// File: rtl/clk_lock_reset_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------------
// clk_lock_reset_ctrl : clock-wizard lock sequencing and core reset release. Rev 1.0
// ------------------------------------------------------------------------
module clk_lock_reset_ctrl
  import clk_rst_pkg::*;
#(
  parameter int PULSE_CYCLES   = DEF_PULSE_CYCLES,
  parameter int HOLD_CYCLES    = DEF_HOLD_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       locked,
  output logic       wiz_reset,
  output logic       sys_reset,
  output logic       ready,
  output logic [7:0] relock_count,
  output logic       timeout_err
);

  localparam int CNT_W = cnt_width(max3(PULSE_CYCLES, HOLD_CYCLES, TIMEOUT_CYCLES));

  localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic             locked_s;

  state_t           state_q,        state_d;
  logic [CNT_W-1:0] cnt_q,          cnt_d;
  logic             wiz_reset_q,    wiz_reset_d;
  logic             sys_reset_q,    sys_reset_d;
  logic             ready_q,        ready_d;
  logic [7:0]       relock_count_q, relock_count_d;
  logic             timeout_err_q,  timeout_err_d;

  sync_2ff u_locked_sync (
    .clk (clk),
    .rst (reset),
    .d   (locked),
    .q   (locked_s)
  );

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    relock_count_d = relock_count_q;
    timeout_err_d  = timeout_err_q;

    case (state_q)
      ST_PULSE: begin
        if (cnt_q == PULSE_LAST) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WAIT_LOCK: begin
        // Lock is tested first so it wins over a coinciding timeout.
        if (locked_s) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d       = ST_PULSE;
          cnt_d         = '0;
          timeout_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (!locked_s) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RUN: begin
        if (!locked_s) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
          if (relock_count_q != 8'hFF) begin
            relock_count_d = relock_count_q + 8'd1;
          end
        end
      end
      default: begin
        state_d = ST_PULSE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_comb begin
    wiz_reset_d = (state_d == ST_PULSE);
    sys_reset_d = (state_d != ST_RUN);
    ready_d     = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_PULSE;
      cnt_q          <= '0;
      wiz_reset_q    <= 1'b1;
      sys_reset_q    <= 1'b1;
      ready_q        <= 1'b0;
      relock_count_q <= 8'd0;
      timeout_err_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      wiz_reset_q    <= wiz_reset_d;
      sys_reset_q    <= sys_reset_d;
      ready_q        <= ready_d;
      relock_count_q <= relock_count_d;
      timeout_err_q  <= timeout_err_d;
    end
  end

  assign wiz_reset    = wiz_reset_q;
  assign sys_reset    = sys_reset_q;
  assign ready        = ready_q;
  assign relock_count = relock_count_q;
  assign timeout_err  = timeout_err_q;

endmodule
`default_nettype wire
